// File: rtl/my_fsm_pkg.sv
// ============================================================================
// Module   : my_fsm_pkg
// Purpose  : Shared state encoding and transition function for the 1,1,0 detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package my_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S11  = 2'd2,
    DET  = 2'd3
  } state_e;

  localparam logic [1:0] C_STATE_W = 2'd2;

  // After DET only the trailing 1s can start a new match, so DET behaves like IDLE.
  function automatic state_e fsm_next(input state_e cur, input logic bit_in);
    state_e nxt;
    case (cur)
      IDLE:    nxt = bit_in ? S1  : IDLE;
      S1:      nxt = bit_in ? S11 : IDLE;
      S11:     nxt = bit_in ? S11 : DET;
      DET:     nxt = bit_in ? S1  : IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/my_fsm.sv
// ============================================================================
// Module   : my_fsm
// Purpose  : Moore FSM flagging the serial pattern 1,1,0 with a registered pulse.
// Options  : MY_FSM_STATE_OUT_EN adds the 2-bit state_o observation port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module my_fsm
  import my_fsm_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       in,
  output logic       out
`ifdef MY_FSM_STATE_OUT_EN
  ,
  output logic [1:0] state_o
`endif
);

  state_e state_q, state_d;
  logic   out_q,   out_d;

  always_comb begin
    state_d = fsm_next(state_q, in);
    // Flag is precomputed from the next state so it lands with the DET register.
    out_d   = (state_d == DET);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

`ifdef MY_FSM_STATE_OUT_EN
  assign state_o = state_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_my_fsm.sv
// ============================================================================
// Module   : tb_my_fsm
// Purpose  : Self-checking bench for my_fsm: directed cases plus random stream
//            checked against a sliding-window model of the 1,1,0 pattern.
// Options  : MY_FSM_STATE_OUT_EN enables state_o checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_my_fsm;

  logic clk;
  logic rst;
  logic din;
  logic dout;
`ifdef MY_FSM_STATE_OUT_EN
  logic [1:0] state_obs;
`endif

  int checks   = 0;
  int failures = 0;

  // Bits sampled since the most recent reset edge.
  logic hist[$];

  my_fsm dut (
    .clock   (clk),
    .reset   (rst),
    .in      (din),
    .out     (dout)
`ifdef MY_FSM_STATE_OUT_EN
    ,
    .state_o (state_obs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_out();
    int n;
    n = hist.size();
    if (n < 3) return 1'b0;
    return (hist[n-3] == 1'b1) && (hist[n-2] == 1'b1) && (hist[n-1] == 1'b0);
  endfunction

  // Apply one cycle of inputs, advance the model, and sample just after the edge.
  task automatic step(input logic r, input logic b);
    rst = r;
    din = b;
    @(posedge clk);
    #1;
    if (r) hist.delete();
    else   hist.push_back(b);
  endtask

  task automatic chk_out(input string tag, input logic exp);
    checks++;
    assert (dout === exp)
    else begin
      failures++;
      $error("FAIL %s out=%0b expected=%0b", tag, dout, exp);
    end
  endtask

`ifdef MY_FSM_STATE_OUT_EN
  task automatic chk_state(input string tag, input logic [1:0] exp);
    checks++;
    assert (state_obs === exp)
    else begin
      failures++;
      $error("FAIL %s state_o=%0d expected=%0d", tag, state_obs, exp);
    end
  endtask
`endif

  initial begin
    logic b, r;
    rst = 1'b1;
    din = 1'b0;
    @(negedge clk);

    // Reset, then a single 0
    step(1'b1, 1'b1); chk_out("reset", 1'b0);
`ifdef MY_FSM_STATE_OUT_EN
    chk_state("reset_state", 2'd0);
`endif
    step(1'b0, 1'b0); chk_out("post_reset_0", 1'b0);

    // Basic pattern
    step(1'b0, 1'b1); chk_out("basic_e1", 1'b0);
    step(1'b0, 1'b1); chk_out("basic_e2", 1'b0);
    step(1'b0, 1'b0); chk_out("basic_e3", 1'b1);
    step(1'b0, 1'b0); chk_out("basic_e4", 1'b0);
    step(1'b0, 1'b0); chk_out("basic_e5", 1'b0);

    // Long run of ones
    step(1'b0, 1'b1); chk_out("run_e1", 1'b0);
    step(1'b0, 1'b1); chk_out("run_e2", 1'b0);
    step(1'b0, 1'b1); chk_out("run_e3", 1'b0);
    step(1'b0, 1'b1); chk_out("run_e4", 1'b0);
    step(1'b0, 1'b0); chk_out("run_e5", 1'b1);

    // Back-to-back patterns
    step(1'b0, 1'b1); chk_out("b2b_e1", 1'b0);
    step(1'b0, 1'b1); chk_out("b2b_e2", 1'b0);
    step(1'b0, 1'b0); chk_out("b2b_e3", 1'b1);
    step(1'b0, 1'b1); chk_out("b2b_e4", 1'b0);
    step(1'b0, 1'b1); chk_out("b2b_e5", 1'b0);
    step(1'b0, 1'b0); chk_out("b2b_e6", 1'b1);

    // Reset from S11 discards the partial pattern
    step(1'b0, 1'b1); chk_out("mid_e1", 1'b0);
    step(1'b0, 1'b1); chk_out("mid_e2", 1'b0);
    step(1'b1, 1'b0); chk_out("mid_rst", 1'b0);
`ifdef MY_FSM_STATE_OUT_EN
    chk_state("mid_rst_state", 2'd0);
`endif
    step(1'b0, 1'b0); chk_out("mid_after", 1'b0);

    // Near miss 1,0,1,0
    step(1'b0, 1'b1); chk_out("near_e1", 1'b0);
`ifdef MY_FSM_STATE_OUT_EN
    chk_state("near_s1", 2'd1);
`endif
    step(1'b0, 1'b0); chk_out("near_e2", 1'b0);
`ifdef MY_FSM_STATE_OUT_EN
    chk_state("near_s2", 2'd0);
`endif
    step(1'b0, 1'b1); chk_out("near_e3", 1'b0);
`ifdef MY_FSM_STATE_OUT_EN
    chk_state("near_s3", 2'd1);
`endif
    step(1'b0, 1'b0); chk_out("near_e4", 1'b0);
`ifdef MY_FSM_STATE_OUT_EN
    chk_state("near_s4", 2'd0);
`endif

    // Random stream with occasional resets, scored by the window model
    for (int i = 0; i < 400; i++) begin
      b = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 19) == 0);
      step(r, b);
      chk_out("random", model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/my_fsm.md
MY_FSM -- requirements
Module: my_fsm

Interface
Parameters: none.
- REQ-001: The module SHALL have port `clock`, input, 1 bit: the single clock; all state updates occur on its rising edge.
- REQ-002: The module SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
- REQ-003: The module SHALL have port `in`, input, 1 bit: serial data bit, sampled on each rising clock edge.
- REQ-004: The module SHALL have port `out`, output, 1 bit: registered detection flag.
- REQ-005: The design SHALL use one clock, with reset synchronous and active-high.

Function
- REQ-006: The module SHALL be a Moore FSM that detects the serial pattern 1,1,0 on `in`.
- REQ-007: The FSM SHALL have four states:
  - IDLE: no progress.
  - S1: one 1 seen.
  - S11: two or more consecutive 1s seen.
  - DET: pattern complete.
- REQ-008: IDLE SHALL go to S1 when in=1, else stay in IDLE.
- REQ-009: S1 SHALL go to S11 when in=1, else go to IDLE.
- REQ-010: S11 SHALL stay in S11 when in=1 (run of 1s), else go to DET.
- REQ-011: DET SHALL go to S1 when in=1, else go to IDLE (overlap allowed from the trailing edge only).
- REQ-012: `out` SHALL be 1 exactly while the state is DET and 0 in every other state; no combinational path SHALL exist from `in` to `out`.
- REQ-013: Latency: `out` SHALL rise on the same rising edge that samples the final 0 of the pattern, and SHALL stay high for exactly one cycle unless the pattern recurs.
- REQ-014: A run of N≥2 ones followed by a 0 SHALL produce exactly one single-cycle pulse.
- REQ-015: Back-to-back patterns 1,1,0,1,1,0 SHALL produce two pulses, 3 cycles apart.
- REQ-016: X/Z on `in` is not required to be handled; the state encoding SHALL have no unreachable state that can lock up, and the default branch SHALL go to IDLE.

Reset
- REQ-017: While `reset`=1 at a rising edge, the next state SHALL be IDLE and `out` SHALL be 0, regardless of `in`.
- REQ-018: Reset SHALL have priority over all transitions, including reset asserted in S11 or DET.
- REQ-019: Pattern bits sampled while `reset`=1 SHALL not count toward a detection.

Configuration
- REQ-020: When the macro MY_FSM_STATE_OUT_EN is defined, the module SHALL add output port `state_o` (2 bits) carrying the current state encoding: IDLE=0, S1=1, S11=2, DET=3.
- REQ-021: When MY_FSM_STATE_OUT_EN is undefined, `state_o` SHALL be absent and behaviour SHALL otherwise be identical.

Structure
- REQ-022: The state enumeration typedef (2-bit: IDLE, S1, S11, DET) SHALL reside in shared package my_fsm_pkg.
- REQ-023: The module SHALL be a single module with no sub-module: one state register and combinational next-state/output logic.

Verification
- REQ-024: The bench SHALL cover reset behaviour: reset=1 for 1 cycle, then in=0 for 1 cycle -> out=0.
- REQ-025: The bench SHALL cover the basic pattern: after reset, in=1,1,0 on consecutive edges -> out=0,0,1; then in=0 -> out=0; then in=0 -> out=0.
- REQ-026: The bench SHALL cover a long run of ones: in=1,1,1,1,0 -> single pulse on the 5th edge, out=0 on the edges before it.
- REQ-027: The bench SHALL cover overlapping patterns: in=1,1,0,1,1,0 -> out pulses on edges 3 and 6 only.
- REQ-028: The bench SHALL cover reset mid-operation: in=1,1, then reset=1 with in=0 -> out=0 and state IDLE; after release, in=0 -> out=0.
- REQ-029: The bench SHALL cover the near-miss: in=1,0,1,0 -> out stays 0 throughout; with MY_FSM_STATE_OUT_EN defined, check `state_o` follows 1,0,1,0.
